sprite_rom_arbiter: RTL and testbench

Time-shares one single-port 20x20 sprite block ROM, holding 4-bit palette indices, among several sprite renderers (box, fireboy, watergirl instances) in the same clock domain. Requesters present a ROM address with a request. The block grants one requester per cycle, round-robin, and returns the ROM word tagged with the requester ID. It sits between the per-sprite draw logic and the shared block ROM/palette pair, in the vga_clk domain.

---
 rtl/sprite_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/sprite_rom_arbiter.sv | 92 +++++++++
 tb/tb_sprite_rom_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite ROM geometry, widths and typedefs
package sprite_pkg;
    localparam int SPRITE_W  = 20;
    localparam int SPRITE_H  = 20;
    localparam int ROM_DEPTH = SPRITE_W * SPRITE_H;
    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 4;

    localparam logic [DATA_W-1:0] TRANSPARENT_IDX = 4'h0;

    typedef logic [ADDR_W-1:0] rom_addr_t;
    typedef logic [DATA_W-1:0] pal_idx_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] grant_idx
);
    always_comb begin
        logic found;
        int   j;
        gnt       = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found     = 1'b1;
                gnt[j]    = 1'b1;
                grant_idx = $clog2(N)'(j);
            end
        end
    end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin time-sharing of one sprite block ROM
module sprite_rom_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 4,
    parameter int ROM_DEPTH = 400
) (
    input  logic                         vga_clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [DATA_W-1:0]            rom_q,
    output logic                         rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_err
);
    import sprite_pkg::*;

    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0]     r_ptr;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IDW-1:0]     w_idx;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic               w_accept;
    logic               w_oor;

    logic               r_s1_valid;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [IDW-1:0]     r_s1_id;
    logic               r_s1_err;

    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_rsp_err;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (req),
        .ptr       (r_ptr),
        .gnt       (w_gnt),
        .grant_idx (w_idx)
    );

    // Grants are suppressed during reset so nothing is accepted into a clearing pipe.
    assign gnt        = reset_n ? w_gnt : '0;
    assign w_accept   = |gnt;
    assign w_sel_addr = req_addr[w_idx*ADDR_W +: ADDR_W];
    assign w_oor      = 32'(w_sel_addr) >= 32'(ROM_DEPTH);

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_ptr      <= '0;
            r_s1_valid <= 1'b0;
            r_rom_addr <= '0;
            r_s1_id    <= '0;
            r_s1_err   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_ptr      <= (w_idx == IDW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
                r_rom_addr <= w_oor ? '0 : w_sel_addr;
                r_s1_id    <= w_idx;
                r_s1_err   <= w_oor;
            end
        end
    end

    // rom_q is the word for r_rom_addr, read by the ROM on the falling edge.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= r_s1_valid;
            r_rsp_id    <= r_s1_id;
            r_rsp_err   <= r_s1_valid && r_s1_err;
            r_rsp_data  <= (r_s1_valid && !r_s1_err) ? rom_q : DATA_W'(TRANSPARENT_IDX);
        end
    end

    assign rom_addr  = r_rom_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - directed self-checking bench for sprite_rom_arbiter
module tb_sprite_rom_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 4;

    logic                      vga_clk;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_q;
    logic                      rsp_valid;
    logic [1:0]                rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;

    logic [DATA_W-1:0] rom [512];
    int n_pass;
    int n_total;

    sprite_rom_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_DEPTH(400)
    ) dut (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    always @(negedge vga_clk) rom_q <= rom[rom_addr];

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        req      = '0;
        req_addr = '0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        req      = 4'b1111;
        req_addr = '0;
        #1;
        n_total++;
        if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt);
        else n_pass++;
        step();
        step();
        n_total++;
        if ({rom_addr, rsp_valid, rsp_id, rsp_data, rsp_err} !== '0)
            $display("FAIL reset_outputs: got addr=%0d v=%b id=%0d d=%0d e=%b want all 0",
                     rom_addr, rsp_valid, rsp_id, rsp_data, rsp_err);
        else n_pass++;
        reset_n = 1'b1;
        #1;
        n_total++;
        if (gnt !== 4'b0001) $display("FAIL reset_first_prio: got %b want 0001", gnt);
        else n_pass++;
        req = '0;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0010;
        req_addr[1*ADDR_W +: ADDR_W] = 9'd21;
        #1;
        n_total++;
        if (gnt !== 4'b0010) $display("FAIL single_gnt: got %b want 0010", gnt);
        else n_pass++;
        step();
        req = '0;
        n_total++;
        if (rom_addr !== 9'd21 || rsp_valid !== 1'b0)
            $display("FAIL single_stage1: got addr=%0d v=%b want addr=21 v=0", rom_addr, rsp_valid);
        else n_pass++;
        step();
        n_total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 4'h7 || rsp_err !== 1'b0)
            $display("FAIL single_rsp: got v=%b id=%0d d=%0d e=%b want v=1 id=1 d=7 e=0",
                     rsp_valid, rsp_id, rsp_data, rsp_err);
        else n_pass++;
        step();
        n_total++;
        if (rsp_valid !== 1'b0 || rsp_data !== 4'h0)
            $display("FAIL single_after: got v=%b d=%0d want v=0 d=0", rsp_valid, rsp_data);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int          cnt [NUM_REQ];
        logic [8:0]  exp_addr [8];
        logic [1:0]  exp_id [8];
        logic [8:0]  a;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
        for (int c = 0; c < 11; c++) begin
            if (c >= 2 && c < 10) begin
                n_total++;
                if (rsp_valid !== 1'b1 || rsp_id !== exp_id[c-2] ||
                    rsp_data !== rom[exp_addr[c-2]] || rsp_err !== 1'b0)
                    $display("FAIL sat_rsp[%0d]: got v=%b id=%0d d=%0d e=%b want v=1 id=%0d d=%0d e=0",
                             c - 2, rsp_valid, rsp_id, rsp_data, rsp_err, exp_id[c-2], rom[exp_addr[c-2]]);
                else n_pass++;
            end else begin
                n_total++;
                if (rsp_valid !== 1'b0)
                    $display("FAIL sat_idle_rsp[%0d]: got v=%b want 0", c, rsp_valid);
                else n_pass++;
            end
            if (c >= 1 && c <= 8) begin
                n_total++;
                if (rom_addr !== exp_addr[c-1])
                    $display("FAIL sat_rom_addr[%0d]: got %0d want %0d", c - 1, rom_addr, exp_addr[c-1]);
                else n_pass++;
            end
            if (c < 8) begin
                req = 4'b1111;
                for (int i = 0; i < NUM_REQ; i++) begin
                    a = 9'(50 + i * 40 + cnt[i]);
                    req_addr[i*ADDR_W +: ADDR_W] = a;
                end
                #1;
                n_total++;
                if (gnt !== 4'(1 << (c % 4)))
                    $display("FAIL sat_gnt[%0d]: got %b want %b", c, gnt, 4'(1 << (c % 4)));
                else n_pass++;
                exp_id[c]   = 2'(c % 4);
                exp_addr[c] = 9'(50 + (c % 4) * 40 + cnt[c % 4]);
                cnt[c % 4]++;
            end else begin
                req = '0;
            end
            step();
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        req = 4'b1000;
        req_addr[3*ADDR_W +: ADDR_W] = 9'd400;
        #1;
        n_total++;
        if (gnt !== 4'b1000) $display("FAIL oor_gnt: got %b want 1000", gnt);
        else n_pass++;
        step();
        req = '0;
        n_total++;
        if (rom_addr !== 9'd0) $display("FAIL oor_rom_addr: got %0d want 0", rom_addr);
        else n_pass++;
        step();
        n_total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 4'h0 || rsp_err !== 1'b1)
            $display("FAIL oor_rsp: got v=%b id=%0d d=%0d e=%b want v=1 id=3 d=0 e=1",
                     rsp_valid, rsp_id, rsp_data, rsp_err);
        else n_pass++;
        step();
        n_total++;
        if (rsp_err !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL oor_after: got v=%b e=%b want v=0 e=0", rsp_valid, rsp_err);
        else n_pass++;
    endtask

    task automatic test_fairness();
        logic [3:0] req_tab [10];
        logic [3:0] gnt_tab [10];
        req_tab = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                    4'b0101, 4'b0001, 4'b1001, 4'b1001, 4'b1001};
        gnt_tab = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                    4'b0100, 4'b0001, 4'b1000, 4'b0001, 4'b1000};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req = req_tab[c];
            for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = 9'(c + i);
            #1;
            n_total++;
            if (gnt !== gnt_tab[c])
                $display("FAIL fair_gnt[%0d]: got %b want %b", c, gnt, gnt_tab[c]);
            else n_pass++;
            step();
        end
        req = '0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req = 4'b0001;
        req_addr[0 +: ADDR_W] = 9'd10;
        step();
        n_total++;
        if (rom_addr !== 9'd10) $display("FAIL mid_accept: got %0d want 10", rom_addr);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_total++;
        if (gnt !== 4'b0000) $display("FAIL mid_gnt_in_reset: got %b want 0000", gnt);
        else n_pass++;
        step();
        n_total++;
        if ({rom_addr, rsp_valid, rsp_id, rsp_data, rsp_err} !== '0)
            $display("FAIL mid_cleared: got addr=%0d v=%b id=%0d d=%0d e=%b want all 0",
                     rom_addr, rsp_valid, rsp_id, rsp_data, rsp_err);
        else n_pass++;
        reset_n = 1'b1;
        req = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_total++;
            if (rsp_valid !== 1'b0) $display("FAIL mid_no_stale[%0d]: got v=%b want 0", c, rsp_valid);
            else n_pass++;
        end
        req = 4'b1111;
        req_addr[0 +: ADDR_W] = 9'd33;
        #1;
        n_total++;
        if (gnt !== 4'b0001) $display("FAIL mid_ptr_zero: got %b want 0001", gnt);
        else n_pass++;
        step();
        req = '0;
        step();
        n_total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== rom[33])
            $display("FAIL mid_first_after: got v=%b id=%0d d=%0d want v=1 id=0 d=%0d",
                     rsp_valid, rsp_id, rsp_data, rom[33]);
        else n_pass++;
    endtask

    task automatic test_idle();
        do_reset();
        req = 4'b0010;
        req_addr[1*ADDR_W +: ADDR_W] = 9'd5;
        step();
        req = '0;
        step();
        step();
        for (int c = 0; c < 10; c++) begin
            n_total++;
            if (gnt !== 4'b0000 || rsp_valid !== 1'b0 || rsp_data !== 4'h0)
                $display("FAIL idle[%0d]: got gnt=%b v=%b d=%0d want 0000 0 0", c, gnt, rsp_valid, rsp_data);
            else n_pass++;
            step();
        end
        req = 4'b1111;
        #1;
        n_total++;
        if (gnt !== 4'b0100) $display("FAIL idle_ptr_kept: got %b want 0100", gnt);
        else n_pass++;
        req = '0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < 512; i++) rom[i] = 4'((i * 5 + 9) % 16);
        rom[21] = 4'h7;
        rom[10] = 4'h5;
        reset_n  = 1'b0;
        req      = '0;
        req_addr = '0;
        step();
        test_reset();
        test_single();
        test_saturation();
        test_out_of_range();
        test_fairness();
        test_reset_midflight();
        test_idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
